pipe_stage2_issue: RTL and testbench
====================================

# pipe_stage2_issue

Operand issue sequencer feeding the stage-2 compute pipe. Buffers incoming operand/scale/position words in a small FIFO and drives the stage-2 pipe's `stage`, `operand_i`, `scale_i` and `pos` inputs. It steps the stage code 0..6 according to per-stage element counts in `stage_boundary`, then parks at stage 7, the finished code the pipe decodes. It is the transmitting end of the stage/operand interface the stage-2 pipe receives.

## Interface
Parameters:
- `WIDTH`, 16, fp16 lane width
- `parallel_size`, 2, lanes per issued word
- `para`, 8, width of each stage element count and of the internal counter
- `DEPTH`, 4, input FIFO depth in words (power of two, ≥2)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, synchronous, active-low: sampled on `clk`, state cleared when `rst`==0
- `start`  in  1  run request, accepted only while `stage_o`==7
- `stage_boundary`  in  [6:0][para-1:0]  element count per work stage 0..6, sampled at `start` acceptance
- `in_valid`  in  1  input word valid
- `in_ready`  out  1  FIFO can accept
- `in_operand`  in  [parallel_size-1:0][WIDTH-1:0]  operand lanes
- `in_scale`  in  [parallel_size-1:0][WIDTH-1:0]  scale/norm lanes
- `in_pos`  in  [parallel_size-1:0][WIDTH-1:0]  position lanes
- `stage_o`  out  3  stage code to pipe
- `operand_o`, `scale_o`, `pos_o`  out  [parallel_size-1:0][WIDTH-1:0]  FIFO head lanes
- `issue_valid`  out  1  head word is issued this cycle
- `busy`  out  1  `stage_o`!=7
- `done`  out  1  one-cycle pulse on the first cycle of stage 7 after a run

## Operation
- The FIFO stores {operand, scale, pos}, `DEPTH` entries. `in_ready` = !full. A push occurs when `in_valid && in_ready`. There is no full-bypass: a full FIFO refuses a push even when a pop occurs in the same cycle.
- Stage register `stage_o` resets to 7 (idle/finished). Element counter `cnt` (para bits) resets to 0.
- `start` with `stage_o`==7 latches `stage_boundary` into `bnd[6:0]`, clears `cnt`, and sets `stage_o` to 0 on the next edge. `start` while busy is ignored.
- In work stage s (0..6): `issue_valid` = !empty. Each issue pops the head. The pipe has no backpressure, so every issue is consumed.
- On an issue with `cnt`+1 == `bnd[s]`: `cnt` becomes 0 and `stage_o` becomes s+1. Otherwise `cnt` increments.
- Leaving stage 6 enters stage 7, `done` pulses for that one cycle, then the block idles. FIFO contents remaining at finish are kept and issued at the next run.
- Zero-count stage handling is set by the configuration macro below.
- `operand_o`/`scale_o`/`pos_o` always show the FIFO head (last popped value when empty). They are meaningful only with `issue_valid`.
- With `stage_o`==7, `issue_valid` is 0 and nothing pops.
- Reset mid-run: FIFO is flushed (empty), `stage_o`=7, `cnt`=0, `done`=0.

## Timing
- Reset values: `stage_o`=7, `issue_valid`=0, `in_ready`=1, `busy`=0, `done`=0, data outputs 0.
- Push at edge t → head visible and issuable in cycle t+1. Simultaneous push into an empty FIFO and pop do not occur, because empty means no pop.
- `start` sampled at edge t → `stage_o`=0 in cycle t+1. The first issue can occur in cycle t+1.
- `stage_o` and the issued data are coincident: the word issued in a cycle belongs to the `stage_o` shown in that cycle.
- The stage advances on the edge ending the cycle that issues its last element. The next stage's first issue can occur in the following cycle, with no gap cycles.
- A run with all counts nonzero and a FIFO that never empties lasts Σbnd cycles from `stage_o`=0 to `stage_o`=7.
- Maximum count per stage is 2^para−1 (255). The counter never wraps within a stage.

## Configuration
- `PIPE_STAGE2_SKIP_EMPTY_EN` defined: a stage with `bnd`==0 is skipped. Both at `start` and at each advance, `stage_o` goes directly to the next stage with a nonzero count, or to 7 if none remain. An all-zero run goes from idle to 7 in one cycle, and `done` still pulses.
- Not defined: a stage with `bnd`==0 occupies exactly one cycle with `issue_valid`=0 and no pop, then advances. An all-zero run lasts 7 cycles before `done`.

## Test plan
- Reset then idle → `stage_o`=7, `in_ready`=1, `issue_valid`=0, `busy`=0.
- Push 4 words (DEPTH=4), bnd={1,1,1,1,0,0,0} without macro → after 4 pushes `in_ready`=0 with `in_valid` held. `start` → stages 0,1,2,3 each issue one word in order. Stages 4,5,6 are one idle cycle each. `done` pulses in cycle 8 after `start`.
- Same stimulus with `PIPE_STAGE2_SKIP_EMPTY_EN` → `stage_o` goes 3→7 directly, and `done` pulses in cycle 5.
- bnd all 3, source keeps the FIFO non-empty → 21 consecutive `issue_valid` cycles. `stage_o` increments every 3 cycles, and popped pos values follow push order.
- FIFO empties mid-stage 2 (cnt=1) → `issue_valid`=0 and `stage_o` holds at 2. The next push resumes with cnt=2 and the stage advances after that issue.
- `rst`=0 asserted in stage 4 with 2 words buffered → next cycle `stage_o`=7, FIFO empty, `in_ready`=1. `start` during the run is ignored: stage order is unaffected.

Source files
------------

// File: rtl/pipe_stage2_issue.sv
// Operand issue sequencer for the stage-2 compute pipe: a small FIFO of {operand, scale, pos}
// words drained through stage codes 0..6 by per-stage counts. Option: PIPE_STAGE2_SKIP_EMPTY_EN.
module pipe_stage2_issue #(
    parameter int WIDTH         = 16,
    parameter int parallel_size = 2,
    parameter int para          = 8,
    parameter int DEPTH         = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [6:0][para-1:0]                stage_boundary,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [parallel_size-1:0][WIDTH-1:0] in_operand,
    input  logic [parallel_size-1:0][WIDTH-1:0] in_scale,
    input  logic [parallel_size-1:0][WIDTH-1:0] in_pos,
    output logic [2:0]                          stage_o,
    output logic [parallel_size-1:0][WIDTH-1:0] operand_o,
    output logic [parallel_size-1:0][WIDTH-1:0] scale_o,
    output logic [parallel_size-1:0][WIDTH-1:0] pos_o,
    output logic                                issue_valid,
    output logic                                busy,
    output logic                                done
);
    localparam int         AW   = $clog2(DEPTH);
    localparam logic [2:0] IDLE = 3'd7;

    typedef struct packed {
        logic [parallel_size-1:0][WIDTH-1:0] operand;
        logic [parallel_size-1:0][WIDTH-1:0] scale;
        logic [parallel_size-1:0][WIDTH-1:0] pos;
    } entry_t;

    entry_t              mem [DEPTH];
    entry_t              head;
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [AW:0]         count;
    logic                full, empty, push, pop;

    logic [6:0][para-1:0] bnd;
    logic [para-1:0]     cnt, cnt_inc, cur_bnd;
    logic [2:0]          next_stage, start_stage;
    logic                work, last_elem;

`ifdef PIPE_STAGE2_SKIP_EMPTY_EN
    // First stage at or after 'from' with a nonzero count, or IDLE if none remain.
    function automatic logic [2:0] first_live(input logic [6:0][para-1:0] b, input logic [2:0] from);
        first_live = IDLE;
        for (int k = 6; k >= 0; k--) begin
            if (k >= int'(from) && b[k] != '0) first_live = 3'(k);
        end
    endfunction
`endif

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign pop      = issue_valid;
    assign busy     = work;

    always_comb begin
        work    = (stage_o != IDLE);
        cur_bnd = '0;
        if (work) cur_bnd = bnd[stage_o];
        cnt_inc     = cnt + para'(1);
        last_elem   = (cnt_inc == cur_bnd);
        issue_valid = work && !empty && (cur_bnd != '0);
`ifdef PIPE_STAGE2_SKIP_EMPTY_EN
        next_stage  = first_live(bnd, stage_o + 3'd1);
        start_stage = first_live(stage_boundary, 3'd0);
`else
        next_stage  = stage_o + 3'd1;
        start_stage = 3'd0;
`endif
    end

    // When empty the output keeps showing the most recently popped word.
    always_comb begin
        head = empty ? mem[rd_ptr - 1'b1] : mem[rd_ptr];
    end

    assign operand_o = head.operand;
    assign scale_o   = head.scale;
    assign pos_o     = head.pos;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            // NOTE: storage is cleared on reset so the data outputs read 0 before the first push.
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{operand: in_operand, scale: in_scale, pos: in_pos};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stage_o <= IDLE;
            cnt     <= '0;
            done    <= 1'b0;
            bnd     <= '0;
        end else begin
            done <= 1'b0;
            if (!work) begin
                if (start) begin
                    bnd     <= stage_boundary;
                    cnt     <= '0;
                    stage_o <= start_stage;
                    done    <= (start_stage == IDLE);
                end
            end else if (cur_bnd == '0) begin
                // A zero-count stage spends one cycle without issuing.
                stage_o <= next_stage;
                done    <= (next_stage == IDLE);
            end else if (pop) begin
                if (last_elem) begin
                    cnt     <= '0;
                    stage_o <= next_stage;
                    done    <= (next_stage == IDLE);
                end else begin
                    cnt <= cnt_inc;
                end
            end
        end
    end
endmodule

// File: tb/tb_pipe_stage2_issue.sv
// Directed bench for pipe_stage2_issue: reset state, FIFO fill, stage sequencing,
// zero-count stages, streaming run, mid-stage underflow and reset mid-run.
module tb_pipe_stage2_issue;
    localparam int WIDTH = 16;
    localparam int PS    = 2;
    localparam int PARA  = 8;
    localparam int DEPTH = 4;

    typedef logic [PS*WIDTH-1:0] lanes_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                       rst, start, in_valid, in_ready, issue_valid, busy, done;
    logic [6:0][PARA-1:0]       stage_boundary;
    logic [PS-1:0][WIDTH-1:0]   in_operand, in_scale, in_pos, operand_o, scale_o, pos_o;
    logic [2:0]                 stage_o;

    int n_cmp = 0;
    int n_err = 0;
    int q[$];
    int next_id;
    bit full_m;
    int st5[4] = '{0, 1, 1, 2};

    pipe_stage2_issue #(.WIDTH(WIDTH), .parallel_size(PS), .para(PARA), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .stage_boundary(stage_boundary),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_operand(in_operand), .in_scale(in_scale), .in_pos(in_pos),
        .stage_o(stage_o), .operand_o(operand_o), .scale_o(scale_o), .pos_o(pos_o),
        .issue_valid(issue_valid), .busy(busy), .done(done)
    );

    function automatic lanes_t mk(input logic [15:0] base, input int k);
        logic [15:0] a;
        a = base + 16'(k);
        return {a, a + 16'h0100};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_word(input string tag, input int k);
        check({tag, "_operand"}, 64'(operand_o), 64'(mk(16'h1000, k)));
        check({tag, "_scale"},   64'(scale_o),   64'(mk(16'h3000, k)));
        check({tag, "_pos"},     64'(pos_o),     64'(mk(16'h5000, k)));
    endtask

    task automatic drive_word(input int k);
        in_operand = mk(16'h1000, k);
        in_scale   = mk(16'h3000, k);
        in_pos     = mk(16'h5000, k);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_bnd(input logic [7:0] b0, b1, b2, b3, b4, b5, b6);
        stage_boundary = {b6, b5, b4, b3, b2, b1, b0};
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic push_words(input int first, input int n);
        in_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            drive_word(first + i);
            tick();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; stage_boundary = '0;
        drive_word(0);
        tick();
        // reset values
        check("rst_stage", 64'(stage_o), 64'd7);
        check("rst_issue_valid", 64'(issue_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_operand", 64'(operand_o), 64'd0);
        check("rst_pos", 64'(pos_o), 64'd0);
        rst = 1'b1;
        tick();
        check("idle_stage", 64'(stage_o), 64'd7);

        // fill to full, then hold in_valid: the fifth word must be refused
        push_words(0, 4);
        check("full_in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b1; drive_word(4);
        tick();
        check("full_hold_in_ready", 64'(in_ready), 64'd0);
        check("idle_no_issue", 64'(issue_valid), 64'd0);
        check_word("idle_head", 0);
        in_valid = 1'b0;

        // run with stages 4..6 empty; a start mid-run must be ignored
        set_bnd(1, 1, 1, 1, 0, 0, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            check($sformatf("runA_stage_c%0d", c), 64'(stage_o), 64'(c - 1));
            check($sformatf("runA_iv_c%0d", c), 64'(issue_valid), 64'd1);
            check($sformatf("runA_done_c%0d", c), 64'(done), 64'd0);
            check_word($sformatf("runA_word_c%0d", c), c - 1);
            start = (c == 2);
            tick();
        end
        start = 1'b0;
`ifndef PIPE_STAGE2_SKIP_EMPTY_EN
        for (int c = 5; c <= 7; c++) begin
            check($sformatf("runA_zstage_c%0d", c), 64'(stage_o), 64'(c - 1));
            check($sformatf("runA_ziv_c%0d", c), 64'(issue_valid), 64'd0);
            check($sformatf("runA_zdone_c%0d", c), 64'(done), 64'd0);
            check($sformatf("runA_zbusy_c%0d", c), 64'(busy), 64'd1);
            tick();
        end
`endif
        check("runA_end_stage", 64'(stage_o), 64'd7);
        check("runA_done", 64'(done), 64'd1);
        check("runA_end_busy", 64'(busy), 64'd0);
        check("runA_end_iv", 64'(issue_valid), 64'd0);
        check("runA_last_popped", 64'(pos_o), 64'(mk(16'h5000, 3)));
        tick();
        check("runA_done_cleared", 64'(done), 64'd0);

        // streaming run, all counts 3: 21 back-to-back issues
        do_reset();
        q.delete();
        next_id = 10;
        push_words(next_id, DEPTH);
        for (int i = 0; i < DEPTH; i++) q.push_back(next_id + i);
        next_id += DEPTH;
        set_bnd(3, 3, 3, 3, 3, 3, 3);
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 21; i++) begin
            check($sformatf("runB_stage_i%0d", i), 64'(stage_o), 64'(i / 3));
            check($sformatf("runB_iv_i%0d", i), 64'(issue_valid), 64'd1);
            check($sformatf("runB_pos_i%0d", i), 64'(pos_o), 64'(mk(16'h5000, q[0])));
            full_m = (q.size() == DEPTH);
            check($sformatf("runB_in_ready_i%0d", i), 64'(in_ready), 64'(!full_m));
            drive_word(next_id);
            tick();
            void'(q.pop_front());
            if (!full_m) begin
                q.push_back(next_id);
                next_id++;
            end
        end
        in_valid = 1'b0;
        check("runB_end_stage", 64'(stage_o), 64'd7);
        check("runB_done", 64'(done), 64'd1);
        check("runB_end_iv", 64'(issue_valid), 64'd0);

        // FIFO runs dry in stage 2 after one of two elements
        do_reset();
        push_words(20, 4);
        set_bnd(1, 2, 2, 1, 1, 1, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check($sformatf("runC_stage_c%0d", c), 64'(stage_o), 64'(st5[c]));
            check($sformatf("runC_iv_c%0d", c), 64'(issue_valid), 64'd1);
            check_word($sformatf("runC_word_c%0d", c), 20 + c);
            tick();
        end
        for (int c = 0; c < 2; c++) begin
            check($sformatf("runC_dry_stage_c%0d", c), 64'(stage_o), 64'd2);
            check($sformatf("runC_dry_iv_c%0d", c), 64'(issue_valid), 64'd0);
            check($sformatf("runC_dry_busy_c%0d", c), 64'(busy), 64'd1);
            if (c == 1) begin
                in_valid = 1'b1;
                drive_word(24);
            end
            tick();
        end
        for (int j = 0; j < 5; j++) begin
            check($sformatf("runC_res_stage_j%0d", j), 64'(stage_o), 64'(2 + j));
            check($sformatf("runC_res_iv_j%0d", j), 64'(issue_valid), 64'd1);
            check($sformatf("runC_res_pos_j%0d", j), 64'(pos_o), 64'(mk(16'h5000, 24 + j)));
            if (j < 4) drive_word(25 + j);
            else in_valid = 1'b0;
            tick();
        end
        check("runC_end_stage", 64'(stage_o), 64'd7);
        check("runC_done", 64'(done), 64'd1);

        // reset in stage 4 with two words buffered; start in stage 1 ignored
        do_reset();
        push_words(30, 4);
        set_bnd(1, 1, 1, 1, 1, 1, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c <= 4; c++) begin
            check($sformatf("runD_stage_c%0d", c), 64'(stage_o), 64'(c));
            check($sformatf("runD_iv_c%0d", c), 64'(issue_valid), 64'd1);
            check($sformatf("runD_pos_c%0d", c), 64'(pos_o), 64'(mk(16'h5000, 30 + c)));
            in_valid = (c == 1 || c == 2);
            drive_word(33 + c);
            start = (c == 1);
            rst = (c != 4);
            tick();
        end
        in_valid = 1'b0;
        start = 1'b0;
        check("runD_rst_stage", 64'(stage_o), 64'd7);
        check("runD_rst_in_ready", 64'(in_ready), 64'd1);
        check("runD_rst_iv", 64'(issue_valid), 64'd0);
        check("runD_rst_busy", 64'(busy), 64'd0);
        check("runD_rst_done", 64'(done), 64'd0);
        rst = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("runD_after_stage", 64'(stage_o), 64'd0);
        check("runD_after_empty", 64'(issue_valid), 64'd0);
        check("runD_after_busy", 64'(busy), 64'd1);
        tick();
        check("runD_wait_stage", 64'(stage_o), 64'd0);
        check("runD_wait_empty", 64'(issue_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
